mprj_wb_watchdog: RTL and testbench
===================================

// Module: mprj_wb_watchdog
// PURPOSE
//  Sits between the management core's exported user-project Wishbone master port (mprj_*) and
//  the user project area. It registers each request and forwards it to the user project.
//  If the user project does not ack within TIMEOUT cycles, the block ends the cycle itself,
//  returns ERR_DATA, latches the failing address and raises an IRQ pulse.
//  This stops an unresponsive user design from hanging the CPU.
// PARAMETERS
//  TIMEOUT   1024          cycles from user-side stb assertion to forced abort; legal range 2..65535
//  ERR_DATA  32'hDEAD_BEEF read data returned on an aborted cycle
// PORTS
//  core_clk       in   1   single clock, all state on rising edge
//  core_rst       in   1   synchronous reset, active-high
//  m_cyc_i        in   1   from core mprj_cyc_o
//  m_stb_i        in   1   from core mprj_stb_o
//  m_we_i         in   1   from core mprj_we_o
//  m_sel_i        in   4   from core mprj_sel_o
//  m_adr_i        in   32  from core mprj_adr_o
//  m_dat_i        in   32  from core mprj_dat_o
//  m_ack_o        out  1   to core mprj_ack_i
//  m_dat_o        out  32  to core mprj_dat_i
//  wb_iena_i      in   1   from core mprj_wb_iena; when 0, u_ack_i/u_dat_i are ignored
//  u_cyc_o        out  1   cycle to user project
//  u_stb_o        out  1   strobe to user project
//  u_we_o         out  1   write enable to user project
//  u_sel_o        out  4   byte selects to user project
//  u_adr_o        out  32  address to user project
//  u_dat_o        out  32  write data to user project
//  u_ack_i        in   1   ack from user project
//  u_dat_i        in   32  read data from user project
//  to_clr_i       in   1   clears the sticky timeout status
//  to_flag_o      out  1   sticky flag: at least one abort has occurred since the last clear
//  to_adr_o       out  32  address of the most recent aborted cycle
//  to_irq_o       out  1   one-cycle pulse on each abort
// BEHAVIOUR
//  - Reset values: every output is 0. FSM = IDLE, counter = 0.
//  - FSM states: IDLE, WAIT, RESP, ABORT.
//  - IDLE: when m_cyc_i & m_stb_i, capture we/sel/adr/dat into registers and go to WAIT.
//    u_cyc_o/u_stb_o rise on the next edge (1-cycle forward latency). Counter is cleared to 0.
//  - WAIT: u_cyc_o = u_stb_o = 1 and u_* outputs hold the captured values. Counter increments each cycle.
//    - u_ack_i & wb_iena_i: capture u_dat_i into m_dat_o, drop u_cyc_o/u_stb_o, go to RESP.
//    - else counter == TIMEOUT-1: drop u_cyc_o/u_stb_o, load m_dat_o = ERR_DATA, go to ABORT.
//    - else m_cyc_i == 0 (master withdrew): drop u_* and go to IDLE with no ack.
//    - Priority on the same cycle: ack, then timeout, then withdraw.
//  - RESP and ABORT: m_ack_o = 1 for exactly one cycle, then go to IDLE.
//    m_dat_o is valid while m_ack_o = 1 and holds until the next capture.
//    Minimum round trip is 3 cycles: req, fwd, ack.
//  - ABORT entry edge: to_flag_o <= 1, to_adr_o <= captured address, to_irq_o pulses for 1 cycle.
//  - A u_ack_i arriving while not in WAIT is ignored, including late acks after an abort.
//  - wb_iena_i == 0 makes the user side look silent, so the cycle ends in timeout.
//  - to_clr_i clears to_flag_o next cycle. If it coincides with ABORT entry, set wins.
//    to_adr_o is not cleared by to_clr_i.
//  - Writes: the captured write data is presented on u_dat_o. m_dat_o is still updated on
//    ack/abort; the master ignores it.
//  - Counter width is $clog2(TIMEOUT); it never wraps because it is cleared on WAIT entry.
//  - Reset mid-cycle: all outputs return to 0 next edge and no ack is issued.
//    The user project sees cyc drop.
// STRUCTURE
//  - mprj_wb_pkg: state enum (IDLE, WAIT, RESP, ABORT), default ERR_DATA constant, and a
//    counter-width function.
//  - Sub-module wb_ack_timer: clear/enable counter with an expired output at TIMEOUT-1.
//    Everything else lives in the top FSM.
// TESTING
//  1. Read adr 32'h3000_0004; user acks 5 cycles after u_stb_o with 32'h1234_5678
//     -> m_ack_o 1 cycle, m_dat_o = 32'h1234_5678, to_flag_o = 0.
//  2. Write adr 32'h3000_0010, sel 4'b0011, dat 32'hA5A5_0F0F; user acks on the first u_stb_o cycle
//     -> u_* match exactly, m_ack_o 3 cycles after request.
//  3. TIMEOUT = 16, user never acks -> u_stb_o drops after 16 cycles, m_ack_o with 32'hDEAD_BEEF,
//     to_irq_o 1 pulse, to_flag_o = 1, to_adr_o = request address.
//     A late u_ack_i 2 cycles later -> no extra m_ack_o.
//  4. wb_iena_i = 0 while the user acks -> timeout path taken, as in scenario 3.
//  5. u_ack_i on the same cycle as counter expiry -> normal ack data returned, to_flag_o unchanged.
//     to_clr_i on the same cycle as an abort -> to_flag_o = 1.
//  6. Assert core_rst while in WAIT -> all outputs 0 next cycle, no m_ack_o.
//     Master drops m_cyc_i in WAIT -> IDLE, no m_ack_o, to_flag_o = 0.

Source files
------------

// File: rtl/mprj_wb_pkg.sv
// Shared definitions for the user-project Wishbone watchdog.
// Holds the FSM state enum, the default abort read data, bus widths
// and the timeout counter width helper.
package mprj_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADR_W  = 32;
  localparam int SEL_W  = 4;

  localparam logic [DATA_W-1:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    ABORT = 2'd3
  } wd_state_e;

  // Counter only has to reach TIMEOUT-1. The floor of 1 bit keeps TIMEOUT=2 legal.
  function automatic int cnt_width(input int timeout);
    return (timeout <= 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mprj_wb_watchdog_if.sv
// Classic Wishbone bus bundle.
//   master modport : drives cyc/stb/we/sel/adr/dat_w, receives ack/dat_r
//   slave modport  : receives cyc/stb/we/sel/adr/dat_w, drives ack/dat_r
interface mprj_wb_watchdog_if;
  import mprj_wb_pkg::*;

  logic              cyc;
  logic              stb;
  logic              we;
  logic [SEL_W-1:0]  sel;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] dat_w;
  logic              ack;
  logic [DATA_W-1:0] dat_r;

  modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
  modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, dat_r);

endinterface

// File: rtl/wb_ack_timer.sv
// Cycle counter for the outstanding user-side request.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force count to 0 (dominates en)
//   en       : increment by one
//   expired  : count has reached TIMEOUT-1
module wb_ack_timer
  import mprj_wb_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = cnt_width(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [CNT_W-1:0] cnt_p0;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_p0 <= '0;
    end else if (en) begin
      cnt_p0 <= cnt_p0 + 1'b1;
    end
  end

  assign expired = (cnt_p0 == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mprj_wb_watchdog.sv
// Watchdog between the management core's user-project Wishbone master and
// the user project. Each request is registered and forwarded; if the user
// side does not ack within TIMEOUT cycles, the cycle is terminated locally
// with ERR_DATA, the address is latched and a one-cycle IRQ is raised.
// Ports:
//   core_clk, core_rst : clock, synchronous active-high reset
//   m_bus              : slave side facing the core (mprj_*)
//   u_bus              : master side facing the user project
//   wb_iena_i          : when low, user ack/data are ignored
//   to_clr_i           : clears the sticky timeout flag
//   to_flag_o          : sticky "abort occurred" flag
//   to_adr_o           : address of most recent aborted cycle
//   to_irq_o           : one-cycle pulse per abort
module mprj_wb_watchdog
  import mprj_wb_pkg::*;
#(
  parameter int                TIMEOUT  = 1024,
  parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
  input  logic                 core_clk,
  input  logic                 core_rst,
  mprj_wb_watchdog_if.slave    m_bus,
  mprj_wb_watchdog_if.master   u_bus,
  input  logic                 wb_iena_i,
  input  logic                 to_clr_i,
  output logic                 to_flag_o,
  output logic [ADR_W-1:0]     to_adr_o,
  output logic                 to_irq_o
);

  wd_state_e state_q, state_d;

  logic req_take;
  logic rsp_load;
  logic abort_load;
  logic expired;
  logic user_ack;
  logic in_wait;

  logic              req_we_p0;
  logic [SEL_W-1:0]  req_sel_p0;
  logic [ADR_W-1:0]  req_adr_p0;
  logic [DATA_W-1:0] req_dat_p0;
  logic [DATA_W-1:0] rsp_dat_p1;
  logic              flag_q;
  logic [ADR_W-1:0]  to_adr_q;
  logic              irq_q;

  assign user_ack = u_bus.ack & wb_iena_i;
  assign in_wait  = (state_q == WAIT);

  wb_ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (core_clk),
    .rst     (core_rst),
    .clr     (!in_wait),
    .en      (in_wait),
    .expired (expired)
  );

  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Ack beats timeout, timeout beats master withdrawal.
  always_comb begin
    state_d    = state_q;
    req_take   = 1'b0;
    rsp_load   = 1'b0;
    abort_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_bus.cyc && m_bus.stb) begin
          state_d  = WAIT;
          req_take = 1'b1;
        end
      end
      WAIT: begin
        if (user_ack) begin
          state_d  = RESP;
          rsp_load = 1'b1;
        end else if (expired) begin
          state_d    = ABORT;
          abort_load = 1'b1;
        end else if (!m_bus.cyc) begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p0: request capture; needs no reset since outputs are gated by WAIT.
  always_ff @(posedge core_clk) begin
    if (req_take) begin
      req_we_p0  <= m_bus.we;
      req_sel_p0 <= m_bus.sel;
      req_adr_p0 <= m_bus.adr;
      req_dat_p0 <= m_bus.dat_w;
    end
  end

  // Stage p1: response data and abort status.
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      rsp_dat_p1 <= '0;
      flag_q     <= 1'b0;
      to_adr_q   <= '0;
      irq_q      <= 1'b0;
    end else begin
      irq_q <= abort_load;
      if (rsp_load) begin
        rsp_dat_p1 <= u_bus.dat_r;
      end else if (abort_load) begin
        rsp_dat_p1 <= ERR_DATA;
      end
      if (abort_load) begin
        to_adr_q <= req_adr_p0;
      end
      // Setting on abort takes precedence over a coincident clear.
      if (abort_load) begin
        flag_q <= 1'b1;
      end else if (to_clr_i) begin
        flag_q <= 1'b0;
      end
    end
  end

  assign u_bus.cyc   = in_wait;
  assign u_bus.stb   = in_wait;
  assign u_bus.we    = in_wait & req_we_p0;
  assign u_bus.sel   = in_wait ? req_sel_p0 : '0;
  assign u_bus.adr   = in_wait ? req_adr_p0 : '0;
  assign u_bus.dat_w = in_wait ? req_dat_p0 : '0;

  assign m_bus.ack   = (state_q == RESP) || (state_q == ABORT);
  assign m_bus.dat_r = rsp_dat_p1;

  assign to_flag_o = flag_q;
  assign to_adr_o  = to_adr_q;
  assign to_irq_o  = irq_q;

endmodule

// File: tb/tb_mprj_wb_watchdog.sv
module tb_mprj_wb_watchdog;
  import mprj_wb_pkg::*;

  localparam int TO = 16;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        wb_iena_i;
  logic        to_clr_i;
  logic        to_flag_o;
  logic [31:0] to_adr_o;
  logic        to_irq_o;

  mprj_wb_watchdog_if m_bus ();
  mprj_wb_watchdog_if u_bus ();

  always #5 core_clk = ~core_clk;

  mprj_wb_watchdog #(
    .TIMEOUT  (TO),
    .ERR_DATA (ERR)
  ) dut (
    .core_clk  (core_clk),
    .core_rst  (core_rst),
    .m_bus     (m_bus),
    .u_bus     (u_bus),
    .wb_iena_i (wb_iena_i),
    .to_clr_i  (to_clr_i),
    .to_flag_o (to_flag_o),
    .to_adr_o  (to_adr_o),
    .to_irq_o  (to_irq_o)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        iena;
    int          dly;     // ack on this u_stb cycle index (0 = first)
    logic [31:0] rdata;
    int          clr_at;  // pulse to_clr_i on this u_stb count (-1 none)
    logic        pre_clr;
    logic [31:0] e_dat;
    int          e_stb;
    int          e_lat;
    int          e_irq;
    logic        e_flag;
    logic [31:0] e_toadr;
  } vec_t;

  // Drive at negedge, sample at negedge (outputs settle after posedge).
  task automatic pulse_clr();
    to_clr_i = 1'b1;
    @(negedge core_clk);
    to_clr_i = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                         input logic [31:0] dat, input logic iena, input int dly,
                         input logic [31:0] rdata, input int clr_at,
                         output logic [31:0] got_dat, output int stb_cnt, output int lat,
                         output int irq_cnt, output int umis, output int extra_ack);
    int  c;
    bit  done;
    wb_iena_i   = iena;
    m_bus.cyc   = 1'b1;
    m_bus.stb   = 1'b1;
    m_bus.we    = we;
    m_bus.sel   = sel;
    m_bus.adr   = adr;
    m_bus.dat_w = dat;
    c = 0; done = 0; stb_cnt = 0; lat = 0; irq_cnt = 0; umis = 0; got_dat = '0;
    while (!done && c < TO + 8) begin
      @(negedge core_clk);
      c++;
      to_clr_i = 1'b0;
      if (to_irq_o) irq_cnt++;
      if (m_bus.ack) begin
        done      = 1;
        got_dat   = m_bus.dat_r;
        lat       = c;
        m_bus.cyc = 1'b0;
        m_bus.stb = 1'b0;
        u_bus.ack = 1'b0;
      end else if (u_bus.stb) begin
        stb_cnt++;
        if (u_bus.cyc !== 1'b1 || u_bus.we !== we || u_bus.sel !== sel ||
            u_bus.adr !== adr || u_bus.dat_w !== dat) umis = 1;
        u_bus.ack   = (stb_cnt - 1 == dly);
        u_bus.dat_r = (stb_cnt - 1 == dly) ? rdata : $urandom;
        if (stb_cnt == clr_at) to_clr_i = 1'b1;
      end else begin
        u_bus.ack = 1'b0;
      end
    end
    if (!done) begin
      m_bus.cyc = 1'b0;
      m_bus.stb = 1'b0;
    end
    // Late acks from the user side must be ignored.
    u_bus.ack   = 1'b1;
    u_bus.dat_r = rdata;
    extra_ack   = 0;
    repeat (3) begin
      @(negedge core_clk);
      to_clr_i = 1'b0;
      if (m_bus.ack) extra_ack++;
      if (to_irq_o) irq_cnt++;
    end
    u_bus.ack = 1'b0;
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] gd;
    int gs, gl, gi, gu, ge;
    logic        flag_m;
    logic [31:0] adr_m;
    int          cnt;

    vecs[0] = '{1'b0, 4'hF, 32'h3000_0004, 32'h0, 1'b1, 5,  32'h1234_5678, -1, 1'b0,
                32'h1234_5678, 6, 7, 0, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 4'b0011, 32'h3000_0010, 32'hA5A5_0F0F, 1'b1, 0, 32'h0000_1111, -1, 1'b0,
                32'h0000_1111, 1, 2, 0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 4'hF, 32'h3000_0020, 32'h0, 1'b1, 99, 32'h77, -1, 1'b0,
                ERR, 16, 17, 1, 1'b1, 32'h3000_0020};
    vecs[3] = '{1'b0, 4'hF, 32'h3000_0030, 32'h0, 1'b0, 2,  32'h55, -1, 1'b0,
                ERR, 16, 17, 1, 1'b1, 32'h3000_0030};
    vecs[4] = '{1'b0, 4'hF, 32'h3000_0040, 32'h0, 1'b1, 15, 32'hCAFE_0001, -1, 1'b0,
                32'hCAFE_0001, 16, 17, 0, 1'b1, 32'h3000_0030};
    vecs[5] = '{1'b0, 4'hF, 32'h3000_0050, 32'h0, 1'b1, 99, 32'h66, 16, 1'b1,
                ERR, 16, 17, 1, 1'b1, 32'h3000_0050};
    vecs[6] = '{1'b1, 4'b1100, 32'h3000_0060, 32'h0102_0304, 1'b1, 3, 32'h9, -1, 1'b1,
                32'h9, 4, 5, 0, 1'b0, 32'h3000_0050};
    vecs[7] = '{1'b0, 4'b0001, 32'h3000_0070, 32'h0, 1'b1, 16, 32'h44, -1, 1'b0,
                ERR, 16, 17, 1, 1'b1, 32'h3000_0070};

    core_rst = 1'b1; wb_iena_i = 1'b1; to_clr_i = 1'b0;
    m_bus.cyc = 0; m_bus.stb = 0; m_bus.we = 0; m_bus.sel = '0; m_bus.adr = '0; m_bus.dat_w = '0;
    u_bus.ack = 0; u_bus.dat_r = '0;
    repeat (3) @(negedge core_clk);
    check("rst_m_ack", 32'(m_bus.ack), 32'h0);
    check("rst_m_dat", m_bus.dat_r, 32'h0);
    check("rst_u_cyc_stb", {30'h0, u_bus.cyc, u_bus.stb}, 32'h0);
    check("rst_u_adr", u_bus.adr, 32'h0);
    check("rst_to_stat", {30'h0, to_flag_o, to_irq_o}, 32'h0);
    check("rst_to_adr", to_adr_o, 32'h0);
    core_rst = 1'b0;
    @(negedge core_clk);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].pre_clr) pulse_clr();
      run_txn(vecs[i].we, vecs[i].sel, vecs[i].adr, vecs[i].dat, vecs[i].iena, vecs[i].dly,
              vecs[i].rdata, vecs[i].clr_at, gd, gs, gl, gi, gu, ge);
      check($sformatf("v%0d_dat", i), gd, vecs[i].e_dat);
      check($sformatf("v%0d_stb_cycles", i), 32'(gs), 32'(vecs[i].e_stb));
      check($sformatf("v%0d_ack_latency", i), 32'(gl), 32'(vecs[i].e_lat));
      check($sformatf("v%0d_irq_pulses", i), 32'(gi), 32'(vecs[i].e_irq));
      check($sformatf("v%0d_u_fields_bad", i), 32'(gu), 32'h0);
      check($sformatf("v%0d_late_acks", i), 32'(ge), 32'h0);
      check($sformatf("v%0d_flag", i), 32'(to_flag_o), 32'(vecs[i].e_flag));
      check($sformatf("v%0d_to_adr", i), to_adr_o, vecs[i].e_toadr);
    end

    // Reset in the middle of a pending user cycle.
    m_bus.cyc = 1; m_bus.stb = 1; m_bus.we = 0; m_bus.adr = 32'h3000_0090; wb_iena_i = 1;
    repeat (3) @(negedge core_clk);
    check("mid_rst_pre_u_cyc", 32'(u_bus.cyc), 32'h1);
    core_rst = 1'b1; m_bus.cyc = 0; m_bus.stb = 0;
    @(negedge core_clk);
    check("mid_rst_u_cyc_stb", {30'h0, u_bus.cyc, u_bus.stb}, 32'h0);
    check("mid_rst_m_ack", 32'(m_bus.ack), 32'h0);
    check("mid_rst_flag", 32'(to_flag_o), 32'h0);
    check("mid_rst_to_adr", to_adr_o, 32'h0);
    check("mid_rst_m_dat", m_bus.dat_r, 32'h0);
    core_rst = 1'b0;
    cnt = 0;
    repeat (3) begin @(negedge core_clk); if (m_bus.ack) cnt++; end
    check("mid_rst_no_ack", 32'(cnt), 32'h0);

    // Master withdraws while the user side is silent.
    m_bus.cyc = 1; m_bus.stb = 1; m_bus.adr = 32'h3000_0080;
    repeat (4) @(negedge core_clk);
    check("wd_u_stb_up", 32'(u_bus.stb), 32'h1);
    m_bus.cyc = 0; m_bus.stb = 0;
    @(negedge core_clk);
    check("wd_u_cyc_down", 32'(u_bus.cyc), 32'h0);
    cnt = 0;
    repeat (TO + 4) begin @(negedge core_clk); if (m_bus.ack || to_irq_o) cnt++; end
    check("wd_no_ack_irq", 32'(cnt), 32'h0);
    check("wd_flag", 32'(to_flag_o), 32'h0);

    // Randomised transactions against a transaction-level model.
    flag_m = 1'b0; adr_m = 32'h0;
    for (int t = 0; t < 30; t++) begin
      logic        r_we, r_iena, abort;
      logic [3:0]  r_sel;
      logic [31:0] r_adr, r_dat, r_rd;
      int          r_dly;
      if ($urandom % 3 == 0) begin pulse_clr(); flag_m = 1'b0; end
      r_we   = 1'($urandom);
      r_sel  = 4'($urandom);
      r_adr  = {16'h3000, 14'($urandom), 2'b00};
      r_dat  = $urandom;
      r_rd   = $urandom;
      r_iena = ($urandom % 4) != 0;
      r_dly  = $urandom_range(0, 20);
      run_txn(r_we, r_sel, r_adr, r_dat, r_iena, r_dly, r_rd, -1, gd, gs, gl, gi, gu, ge);
      abort = !r_iena || (r_dly >= TO);
      if (abort) begin flag_m = 1'b1; adr_m = r_adr; end
      check($sformatf("r%0d_dat", t), gd, abort ? ERR : r_rd);
      check($sformatf("r%0d_stb_cycles", t), 32'(gs), abort ? 32'(TO) : 32'(r_dly + 1));
      check($sformatf("r%0d_irq", t), 32'(gi), 32'(abort));
      check($sformatf("r%0d_u_fields_bad", t), 32'(gu), 32'h0);
      check($sformatf("r%0d_late_acks", t), 32'(ge), 32'h0);
      check($sformatf("r%0d_flag", t), 32'(to_flag_o), 32'(flag_m));
      check($sformatf("r%0d_to_adr", t), to_adr_o, adr_m);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
